// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: turns one 32-bit command word {cmd, addr, len, wdata}
// into a mode-0 SPI frame, and returns read data on the rx stream.
module spi_frame_ctrl (
  input  logic        pclk_i,
  input  logic        rst_n_i,
  input  logic [15:0] spi_clk_div_i,
  input  logic        spi_clk_div_vld_i,
  input  logic [31:0] stream_data_tx_i,
  input  logic        stream_data_tx_vld_i,
  output logic        stream_data_tx_rdy_o,
  output logic [31:0] stream_data_rx_o,
  output logic        stream_data_rx_vld_o,
  input  logic        stream_data_rx_rdy_i,
  output logic        eot_o,
  output logic        busy_o,
  output logic        spi_sck_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    RXOUT,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] div;
  logic [15:0] cnt;
  logic [39:0] tx_sr;
  logic [31:0] rx_sr;
  logic [5:0]  n_bits;
  logic [5:0]  bit_idx;
  logic        is_read;

  logic        cnt_done;
  logic [7:0]  len;
  logic [5:0]  r_bits;

  // Read length: 0 or anything beyond 32 means a full 32-bit read.
  always_comb begin
    len    = stream_data_tx_i[23:16];
    r_bits = ((len == 8'd0) || (len > 8'd32)) ? 6'd32 : len[5:0];
  end

  assign cnt_done = (cnt == (div - 16'd1));

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; a blocking = would make the result depend
  // on statement order inside the block.
  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state                <= IDLE;
      div                  <= 16'd1;
      cnt                  <= '0;
      tx_sr                <= '0;
      rx_sr                <= '0;
      n_bits               <= '0;
      bit_idx              <= '0;
      is_read              <= 1'b0;
      stream_data_tx_rdy_o <= 1'b1;
      stream_data_rx_o     <= '0;
      stream_data_rx_vld_o <= 1'b0;
      eot_o                <= 1'b0;
      busy_o               <= 1'b0;
      spi_sck_o            <= 1'b0;
      spi_cs_n_o           <= 1'b1;
      spi_mosi_o           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stream_data_tx_vld_i) begin
            if (spi_clk_div_vld_i) begin
              div <= (spi_clk_div_i == 16'd0) ? 16'd1 : spi_clk_div_i;
            end
            is_read <= stream_data_tx_i[31];
            // Header in the top byte; write data follows, read bits shift out zeros.
            tx_sr   <= stream_data_tx_i[31] ? {stream_data_tx_i[31:24], 32'd0}
                                            : {stream_data_tx_i[31:24], stream_data_tx_i[15:0], 16'd0};
            n_bits  <= stream_data_tx_i[31] ? (6'd8 + r_bits) : 6'd24;
            rx_sr   <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            stream_data_tx_rdy_o <= 1'b0;
            busy_o               <= 1'b1;
            spi_cs_n_o           <= 1'b0;
            spi_mosi_o           <= stream_data_tx_i[31];
            state                <= SETUP;
          end
        end

        SETUP: begin
          if (cnt_done) begin
            cnt       <= '0;
            spi_sck_o <= 1'b1;
            state     <= SHIFT_HI;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        SHIFT_HI: begin
          if (cnt_done) begin
            cnt        <= '0;
            spi_sck_o  <= 1'b0;
            tx_sr      <= {tx_sr[38:0], 1'b0};
            spi_mosi_o <= tx_sr[38];
            bit_idx    <= bit_idx + 6'd1;
            state      <= SHIFT_LO;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        SHIFT_LO: begin
          if (cnt_done) begin
            cnt <= '0;
            if (bit_idx < n_bits) begin
              spi_sck_o <= 1'b1;
              state     <= SHIFT_HI;
              // bit_idx is the index of the pulse now rising; data bits follow the header.
              if (is_read && (bit_idx >= 6'd8)) begin
                rx_sr <= {rx_sr[30:0], spi_miso_i};
              end
            end else begin
              spi_cs_n_o <= 1'b1;
              if (is_read) begin
                stream_data_rx_vld_o <= 1'b1;
                stream_data_rx_o     <= rx_sr;
                state                <= RXOUT;
              end else begin
                eot_o <= 1'b1;
                state <= DONE;
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        RXOUT: begin
          if (stream_data_rx_rdy_i) begin
            stream_data_rx_vld_o <= 1'b0;
            eot_o                <= 1'b1;
            state                <= DONE;
          end
        end

        DONE: begin
          eot_o                <= 1'b0;
          busy_o               <= 1'b0;
          stream_data_tx_rdy_o <= 1'b1;
          state                <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: directed corner frames plus random
// frames, each compared against a frame model built from the command word.
module tb_spi_frame_ctrl;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [15:0] spi_clk_div;
  logic        spi_clk_div_vld;
  logic [31:0] tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic [31:0] rx_data;
  logic        rx_vld;
  logic        rx_rdy;
  logic        eot;
  logic        busy;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso = 1'b0;

  spi_frame_ctrl dut (
    .pclk_i               (pclk),
    .rst_n_i              (rst_n),
    .spi_clk_div_i        (spi_clk_div),
    .spi_clk_div_vld_i    (spi_clk_div_vld),
    .stream_data_tx_i     (tx_data),
    .stream_data_tx_vld_i (tx_vld),
    .stream_data_tx_rdy_o (tx_rdy),
    .stream_data_rx_o     (rx_data),
    .stream_data_rx_vld_o (rx_vld),
    .stream_data_rx_rdy_i (rx_rdy),
    .eot_o                (eot),
    .busy_o               (busy),
    .spi_sck_o            (sck),
    .spi_cs_n_o           (cs_n),
    .spi_mosi_o           (mosi),
    .spi_miso_i           (miso)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Bus monitor: per-frame statistics, cleared whenever a word is accepted.
  bit   mosi_q[$];
  int   cs_low    = 0;
  int   eot_cnt   = 0;
  int   rxv_cnt   = 0;
  int   stab_err  = 0;
  int   acc_cnt   = 0;
  bit   rise_seen = 1'b0;
  bit   rise_eot  = 1'b0;
  bit   rise_rxv  = 1'b0;
  logic sck_prev  = 1'b0;
  logic mosi_prev = 1'b0;
  logic cs_prev   = 1'b1;

  always @(negedge pclk) begin
    if (tx_vld && tx_rdy) begin
      acc_cnt++;
      mosi_q.delete();
      cs_low    = 0;
      eot_cnt   = 0;
      rxv_cnt   = 0;
      stab_err  = 0;
      rise_seen = 1'b0;
      rise_eot  = 1'b0;
      rise_rxv  = 1'b0;
    end else begin
      if (!cs_n) cs_low++;
      if (sck && !sck_prev) mosi_q.push_back(mosi);
      if (sck && sck_prev && (mosi !== mosi_prev)) stab_err++;
      if (cs_n && sck) stab_err++;
      if (cs_n && !cs_prev && !rise_seen) begin
        rise_seen = 1'b1;
        rise_eot  = eot;
        rise_rxv  = rx_vld;
      end
      if (eot) eot_cnt++;
      if (rx_vld) rxv_cnt++;
    end
    sck_prev  = sck;
    mosi_prev = mosi;
    cs_prev   = cs_n;
  end

  // SPI slave: presents the next read bit after each falling SCK edge, MSB first.
  logic [31:0] slave_word = '0;
  int          slave_r    = 32;
  int          slave_p;
  always @(negedge sck or negedge cs_n) begin
    slave_p = mosi_q.size();
    if ((slave_p >= 8) && ((slave_p - 8) < slave_r)) miso = slave_word[slave_r - 1 - (slave_p - 8)];
    else miso = 1'b0;
  end

  int model_div = 1;

  task automatic run_frame(input logic [31:0] word, input logic [15:0] div, input bit div_vld,
                           input logic [31:0] sw, input int rx_delay, input bit hold_vld,
                           input bit mid_chg, input string tag);
    bit          rd;
    int          r, n, d, acc0, cyc;
    logic [39:0] exp_bits, act_bits;
    logic [31:0] exp_rx, rx0;
    bit          stable;
    rd = word[31];
    r  = ((word[23:16] == 8'd0) || (word[23:16] > 8'd32)) ? 32 : int'(word[23:16]);
    n  = rd ? 8 + r : 24;
    if (div_vld) model_div = (div == 16'd0) ? 1 : int'(div);
    d = model_div;
    exp_bits = '0;
    for (int i = 0; i < n; i++) begin
      if (i < 8) exp_bits[39 - i] = word[31 - i];
      else if (!rd) exp_bits[39 - i] = word[15 - (i - 8)];
    end
    exp_rx     = (r == 32) ? sw : (sw & ((32'd1 << r) - 32'd1));
    slave_word = sw;
    slave_r    = r;
    acc0       = acc_cnt;
    rx0        = '0;
    stable     = 1'b1;

    tx_data         = word;
    tx_vld          = 1'b1;
    spi_clk_div     = div;
    spi_clk_div_vld = div_vld;
    step();
    check({tag, "/accept"}, {tx_rdy, cs_n, busy}, 3'b001);
    tx_vld          = hold_vld;
    tx_data         = ~word;
    spi_clk_div_vld = 1'b0;

    cyc = 0;
    while (!(eot || rx_vld) && (cyc < 20000)) begin
      step();
      cyc++;
      if (mid_chg && (cyc == 10)) begin
        spi_clk_div     = 16'd5;
        spi_clk_div_vld = 1'b1;
      end
    end
    check({tag, "/timeout"}, (cyc < 20000), 1'b1);

    if (rx_vld) begin
      rx0 = rx_data;
      for (int k = 0; k < rx_delay; k++) begin
        step();
        if (!rx_vld || (rx_data !== rx0) || eot) stable = 1'b0;
      end
      rx_rdy = 1'b1;
      step();
      rx_rdy = 1'b0;
      check({tag, "/rx_stable"}, stable, 1'b1);
      check({tag, "/rx_data"}, rx0, exp_rx);
    end
    check({tag, "/eot_cycle"}, {eot, rx_vld, tx_rdy}, 3'b100);
    tx_vld = 1'b0;
    step();
    check({tag, "/idle_after"}, {eot, tx_rdy, busy}, 3'b010);

    act_bits = '0;
    for (int i = 0; (i < mosi_q.size()) && (i < 40); i++) act_bits[39 - i] = mosi_q[i];
    check({tag, "/pulses"}, mosi_q.size(), n);
    check({tag, "/mosi_bits"}, act_bits, exp_bits);
    check({tag, "/cs_low"}, cs_low, (2 * n + 1) * d);
    check({tag, "/eot_cnt"}, eot_cnt, 1);
    check({tag, "/mosi_stab"}, stab_err, 0);
    check({tag, "/rxv_cycles"}, rxv_cnt, rd ? rx_delay + 1 : 0);
    check({tag, "/cs_rise"}, {rise_eot, rise_rxv}, rd ? 2'b01 : 2'b10);
    check({tag, "/accepts"}, acc_cnt - acc0, 1);
  endtask

  initial begin
    int cyc;
    logic [31:0] w;
    rst_n           = 1'b0;
    spi_clk_div     = 16'd1;
    spi_clk_div_vld = 1'b0;
    tx_data         = '0;
    tx_vld          = 1'b0;
    rx_rdy          = 1'b0;
    repeat (3) step();
    check("reset_outs", {tx_rdy, rx_vld, eot, busy, sck, cs_n, mosi}, 7'b1000010);
    check("reset_rx", rx_data, 32'h0);
    rst_n = 1'b1;
    step();

    run_frame(32'h3500A5C3, 16'd1, 1'b1, 32'h0, 0, 1'b0, 1'b0, "wr_d1");
    run_frame(32'h92080000, 16'd2, 1'b1, 32'h000000B7, 0, 1'b0, 1'b0, "rd_d2");
    run_frame(32'h9F001234, 16'd1, 1'b1, 32'hDEADBEEF, 0, 1'b0, 1'b0, "rd_len0");
    run_frame(32'h9A401234, 16'd1, 1'b1, 32'hDEADBEEF, 1, 1'b0, 1'b0, "rd_len40");
    run_frame(32'h1234ABCD, 16'd0, 1'b1, 32'h0, 0, 1'b0, 1'b0, "div0");
    run_frame(32'h4700F00F, 16'd2, 1'b1, 32'h0, 0, 1'b0, 1'b1, "div_mid");
    run_frame(32'h58000F0F, 16'd5, 1'b1, 32'h0, 0, 1'b0, 1'b0, "div_next");
    run_frame(32'hC3100000, 16'd9, 1'b0, 32'h0000C0DE, 2, 1'b0, 1'b0, "div_keep");
    run_frame(32'h8E180000, 16'd1, 1'b1, 32'h00A5F00D, 10, 1'b1, 1'b0, "backpress");

    // Reset in the middle of the 10th SCK pulse of a read frame.
    slave_word = 32'h12345678;
    slave_r    = 32;
    tx_data    = 32'h9F000000;
    tx_vld     = 1'b1;
    spi_clk_div     = 16'd1;
    spi_clk_div_vld = 1'b1;
    step();
    tx_vld          = 1'b0;
    spi_clk_div_vld = 1'b0;
    cyc = 0;
    while (!((mosi_q.size() == 10) && sck) && (cyc < 1000)) begin
      step();
      cyc++;
    end
    check("rst_mid/reach", (cyc < 1000), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid/outs", {cs_n, sck, tx_rdy, busy, eot, rx_vld}, 6'b101000);
    repeat (2) step();
    rst_n     = 1'b1;
    model_div = 1;
    repeat (100) step();
    check("rst_mid/no_eot_rxv", {eot_cnt[15:0], rxv_cnt[15:0]}, 32'h0);
    run_frame(32'h2C00BEEF, 16'd1, 1'b0, 32'h0, 0, 1'b0, 1'b0, "post_rst");

    for (int t = 0; t < 20; t++) begin
      w        = $urandom;
      w[23:16] = 8'($urandom_range(0, 40));
      run_frame(w, 16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
